// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-memory bus bridge.
// Contents:
//   bridge_state_t   - bridge FSM state encoding
//   BRIDGE_TIMEOUT   - default number of REQ cycles allowed before abort
//   BRIDGE_FILL_BYTE - default byte returned to the core on a dead read (6502 NOP)
package bridge_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    REQ    = 2'd1,
    STEP   = 2'd2
  } bridge_state_t;

  localparam int         BRIDGE_TIMEOUT   = 16;
  localparam logic [7:0] BRIDGE_FILL_BYTE = 8'hEA;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter that bounds how long a memory request may stay outstanding.
// Ports:
//   clk     in   system clock
//   nrst    in   asynchronous active-low reset
//   clear   in   synchronous return to zero (takes priority over enable)
//   enable  in   count one cycle
//   expire  out  high while the count equals TIMEOUT_CYCLES-1
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CtrW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CtrW-1:0] LastCount = CtrW'(TIMEOUT_CYCLES - 1);

  logic [CtrW-1:0] countReg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      countReg <= '0;
    end else if (clear) begin
      countReg <= '0;
    end else if (enable) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign expire = (countReg == LastCount);

endmodule

// File: rtl/mem_bus_bridge.sv
// Handshake bridge between the 6502-style core and external memory. Each core
// bus cycle is latched, run as one req/ack memory transaction, and followed by
// a single-cycle cpu_step that advances the core's flip-flops.
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   cpu_addr/wdata/rnw/sync core bus outputs, stable between cpu_step pulses
//   cpu_step                one-cycle enable for the core's flip-flops
//   cpu_rdata               registered read data for the core
//   mem_req/we/addr/wdata   memory request (level, held until ack or timeout)
//   mem_ack, mem_rdata      memory completion pulse and read data
//   halt                    debug freeze, only honoured before a transaction starts
//   err_clr, bus_error      clear / sticky timeout flag (set wins over clear)
//   fetch_count             completed opcode-fetch cycles, wraps
module mem_bus_bridge
  import bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = BRIDGE_TIMEOUT,
  parameter logic [7:0] FILL_BYTE      = BRIDGE_FILL_BYTE,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_wdata,
  input  logic             cpu_rnw,
  input  logic             cpu_sync,
  output logic             cpu_step,
  output logic [7:0]       cpu_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  input  logic             halt,
  input  logic             err_clr,
  output logic             bus_error,
  output logic [CNT_W-1:0] fetch_count
);

  bridge_state_t stateReg, stateNext;

  logic             memWeReg;
  logic [15:0]      memAddrReg;
  logic [7:0]       memWdataReg;
  logic             syncReg;
  logic [7:0]       rdataReg;
  logic             busErrorReg;
  logic [CNT_W-1:0] fetchCountReg;

  logic latchBus;
  logic ackTaken;
  logic timedOut;
  logic ctrClear;
  logic ctrEnable;
  logic ctrExpire;

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk   (clk),
    .nrst  (nrst),
    .clear (ctrClear),
    .enable(ctrEnable),
    .expire(ctrExpire)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateReg <= SETTLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    latchBus  = 1'b0;
    ackTaken  = 1'b0;
    timedOut  = 1'b0;
    ctrClear  = 1'b0;
    ctrEnable = 1'b0;
    case (stateReg)
      SETTLE: begin
        // The counter is held at zero for every SETTLE cycle so a halted
        // bridge always starts its next request with a full budget.
        ctrClear = 1'b1;
        if (!halt) begin
          latchBus  = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ackTaken  = 1'b1;
          stateNext = STEP;
        end else if (ctrExpire) begin
          timedOut  = 1'b1;
          stateNext = STEP;
        end else begin
          ctrEnable = 1'b1;
        end
      end
      STEP: begin
        stateNext = SETTLE;
      end
      default: begin
        stateNext = SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      memWeReg      <= 1'b0;
      memAddrReg    <= '0;
      memWdataReg   <= '0;
      syncReg       <= 1'b0;
      rdataReg      <= '0;
      busErrorReg   <= 1'b0;
      fetchCountReg <= '0;
    end else begin
      if (latchBus) begin
        memWeReg    <= ~cpu_rnw;
        memAddrReg  <= cpu_addr;
        memWdataReg <= cpu_wdata;
        syncReg     <= cpu_sync;
      end

      // Writes leave the core's input latch untouched.
      if (ackTaken && !memWeReg) begin
        rdataReg <= mem_rdata;
      end else if (timedOut && !memWeReg) begin
        rdataReg <= FILL_BYTE;
      end

      if (timedOut) begin
        busErrorReg <= 1'b1;
      end else if (err_clr) begin
        busErrorReg <= 1'b0;
      end

      if ((stateReg == STEP) && syncReg) begin
        fetchCountReg <= fetchCountReg + 1'b1;
      end
    end
  end

  // Request and step are decoded straight from the state register: both are
  // glitch-free and the asynchronous reset drops them immediately.
  assign mem_req     = (stateReg == REQ);
  assign cpu_step    = (stateReg == STEP);
  assign mem_we      = memWeReg;
  assign mem_addr    = memAddrReg;
  assign mem_wdata   = memWdataReg;
  assign cpu_rdata   = rdataReg;
  assign bus_error   = busErrorReg;
  assign fetch_count = fetchCountReg;

endmodule
